// File: rtl/audio_pkg.sv
// Shared audio constants and frame-timing helper for the I2S output path and its siblings.
package audio_pkg;

  localparam int unsigned AUDIO_SAMPLE_WIDTH = 16;
  localparam int unsigned I2S_SLOT_BITS      = 32;
  localparam int unsigned FRAME_RATE_HZ      = 48000;

  function automatic int unsigned i2s_frame_clocks(input int unsigned half, input int unsigned slot);
    return 4 * half * slot;
  endfunction

endpackage

// File: rtl/i2s_bit_clock_gen.sv
// Bit-clock divider: toggles bitClock every CLOCKS_PER_HALF_BIT audioClock cycles and flags each edge.
module i2s_bit_clock_gen #(
  parameter int unsigned CLOCKS_PER_HALF_BIT = 2
) (
  input  logic audioClock,
  input  logic reset,
  output logic bitClock,
  output logic fallStrobe,
  output logic riseStrobe
);

  localparam int unsigned CW = (CLOCKS_PER_HALF_BIT > 1) ? $clog2(CLOCKS_PER_HALF_BIT) : 1;

  logic [CW-1:0] halfCounter_q, halfCounter_d;
  logic          bitClock_q, bitClock_d;
  logic          wrap;

  always_comb begin
    wrap          = (halfCounter_q == CW'(CLOCKS_PER_HALF_BIT - 1));
    halfCounter_d = wrap ? '0 : halfCounter_q + CW'(1);
    bitClock_d    = wrap ? ~bitClock_q : bitClock_q;
    // Strobes coincide with the edge on which bitClock toggles.
    fallStrobe    = wrap & bitClock_q;
    riseStrobe    = wrap & ~bitClock_q;
  end

  always_ff @(posedge audioClock) begin
    if (reset) begin
      halfCounter_q <= '0;
      bitClock_q    <= 1'b0;
    end else begin
      halfCounter_q <= halfCounter_d;
      bitClock_q    <= bitClock_d;
    end
  end

  assign bitClock = bitClock_q;

endmodule

// File: rtl/i2s_transmitter.sv
// I2S frame master: requests a sample pair per frame, captures it at slot 0 and
// shifts it out MSB first with the standard one-bit delay after the word-select change.
module i2s_transmitter
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH        = AUDIO_SAMPLE_WIDTH,
  parameter int unsigned SLOT_BITS           = I2S_SLOT_BITS,
  parameter int unsigned CLOCKS_PER_HALF_BIT = 2
) (
  input  logic                           audioClock,
  input  logic                           reset,
  input  logic signed [SAMPLE_WIDTH-1:0] leftSample,
  input  logic signed [SAMPLE_WIDTH-1:0] rightSample,
  output logic                           sampleEnable,
  output logic                           bitClock,
  output logic                           leftRightClock,
  output logic                           serialData
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned IW         = $clog2(FRAME_BITS);

  logic                  fallStrobe;
  logic                  riseStrobe_unused;
  logic [IW-1:0]         bitIndex_q, bitIndex_d, nextIndex;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  leftRight_q, leftRight_d;
  logic                  serial_q, serial_d;
  logic                  sampleEnable_q, sampleEnable_d;

  i2s_bit_clock_gen #(
    .CLOCKS_PER_HALF_BIT(CLOCKS_PER_HALF_BIT)
  ) u_bit_clock_gen (
    .audioClock (audioClock),
    .reset      (reset),
    .bitClock   (bitClock),
    .fallStrobe (fallStrobe),
    .riseStrobe (riseStrobe_unused)
  );

  always_comb begin
    bitIndex_d     = bitIndex_q;
    shift_d        = shift_q;
    leftRight_d    = leftRight_q;
    serial_d       = serial_q;
    sampleEnable_d = 1'b0;
    nextIndex      = (bitIndex_q == IW'(FRAME_BITS - 1)) ? '0 : bitIndex_q + IW'(1);
    if (fallStrobe) begin
      bitIndex_d     = nextIndex;
      leftRight_d    = (nextIndex >= IW'(SLOT_BITS));
      sampleEnable_d = (nextIndex == IW'(FRAME_BITS - 2));
      // The MSB leaving at slot 0 is the old frame's last bit; the new frame
      // loads behind it, which yields the one-bit delay without a separate stage.
      serial_d       = shift_q[FRAME_BITS-1];
      if (nextIndex == '0) begin
        shift_d = '0;
        shift_d[FRAME_BITS-1 -: SAMPLE_WIDTH] = leftSample;
        shift_d[SLOT_BITS-1  -: SAMPLE_WIDTH] = rightSample;
      end else begin
        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge audioClock) begin
    if (reset) begin
      bitIndex_q     <= IW'(FRAME_BITS - 1);
      shift_q        <= '0;
      leftRight_q    <= 1'b0;
      serial_q       <= 1'b0;
      sampleEnable_q <= 1'b0;
    end else begin
      bitIndex_q     <= bitIndex_d;
      shift_q        <= shift_d;
      leftRight_q    <= leftRight_d;
      serial_q       <= serial_d;
      sampleEnable_q <= sampleEnable_d;
    end
  end

  assign sampleEnable   = sampleEnable_q;
  assign leftRightClock = leftRight_q;
  assign serialData     = serial_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: cycle-exact arithmetic reference of I2S frame timing and data.
module tb_i2s_transmitter;
  localparam int unsigned W  = 16;
  localparam int unsigned S  = 32;
  localparam int unsigned C  = 2;
  localparam int unsigned FB = 2 * S;
  localparam int unsigned FC = audio_pkg::i2s_frame_clocks(C, S);

  logic clk = 1'b0;
  logic rst;
  logic signed [W-1:0] left, right;
  logic se, bclk, lr, sd;

  always #5 clk = ~clk;

  i2s_transmitter #(
    .SAMPLE_WIDTH(W),
    .SLOT_BITS(S),
    .CLOCKS_PER_HALF_BIT(C)
  ) dut (
    .audioClock     (clk),
    .reset          (rst),
    .leftSample     (left),
    .rightSample    (right),
    .sampleEnable   (se),
    .bitClock       (bclk),
    .leftRightClock (lr),
    .serialData     (sd)
  );

  int unsigned t;
  bit          chk_en = 1'b0;
  logic [W-1:0] cap_l [512];
  logic [W-1:0] cap_r [512];
  logic [W-1:0] tbl [48];
  int n_assert = 0;
  int n_fail   = 0;

  // t = active edges since reset released; samples seen at each slot-0 fall are recorded per frame.
  always @(posedge clk) begin
    if (rst) begin
      t = 0;
    end else begin
      t = t + 1;
      if (t % (2 * C) == 0 && ((t / (2 * C)) - 1) % FB == 0) begin
        cap_l[(((t / (2 * C)) - 1) / FB) % 512] = left;
        cap_r[(((t / (2 * C)) - 1) / FB) % 512] = right;
      end
    end
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    int unsigned m, b, p, f, k, ch;
    logic e_bclk, e_lr, e_sd, e_se;
    if (chk_en) begin
      e_bclk = ((t / C) % 2) == 1;
      m = t / (2 * C);
      e_lr = 1'b0; e_sd = 1'b0; e_se = 1'b0;
      if (m != 0) begin
        b = (m - 1) % FB;
        f = (m - 1) / FB;
        e_lr = (b >= S);
        e_se = (t % (2 * C) == 0) && (b == FB - 2);
        p  = (b + FB - 1) % FB;
        ch = p / S;
        k  = p % S;
        if (b != 0 && k < W)
          e_sd = (ch == 1) ? cap_r[f % 512][W-1-k] : cap_l[f % 512][W-1-k];
      end
      chk("bitClock", bclk, e_bclk);
      chk("leftRightClock", lr, e_lr);
      chk("serialData", sd, e_sd);
      chk("sampleEnable", se, e_se);
    end
  end

  task automatic wait_bidx(input int unsigned b);
    bit hit = 1'b0;
    for (int i = 0; i < 2 * FC && !hit; i++) begin
      @(negedge clk);
      if (t % (2 * C) == 0 && t >= 2 * C && ((t / (2 * C)) - 1) % FB == b) hit = 1'b1;
    end
    n_assert++;
    assert (hit) else begin
      n_fail++;
      $error("FAIL wait_bitIndex%0d observed=timeout expected=reached", b);
    end
  endtask

  initial begin
    int unsigned idx;
    for (int i = 0; i < 48; i++)
      tbl[i] = W'($rtoi(32767.0 * $sin(2.0 * 3.14159265358979 * i / 48.0)));
    rst = 1'b1; left = '0; right = '0;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // fixed pattern, three frames
    left = 16'sh8001; right = 16'sh7FFE;
    repeat (3 * FC + 8) @(negedge clk);

    // capture isolation: change left mid-frame
    left = 16'sh1234;
    wait_bidx(0);
    wait_bidx(5);
    left = 16'shFFFF;
    repeat (2 * FC) @(negedge clk);

    // randomized inputs changing at arbitrary cycles
    repeat (4 * FC) begin
      @(negedge clk);
      if ($urandom_range(0, 31) == 0) begin
        left  = W'($urandom);
        right = W'($urandom);
      end
    end

    // one-cycle reset mid-frame
    wait_bidx(20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * FC + 8) @(negedge clk);

    // sine generator responding to sampleEnable on both channels
    idx = 0;
    repeat (50 * FC) begin
      @(negedge clk);
      if (se === 1'b1) begin
        left  = tbl[idx];
        right = tbl[idx];
        idx   = (idx + 1) % 48;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
